// File: rtl/serial_pattern_sender_if.sv
// Handshake and serial-output bundle for serial_pattern_sender.
// The master side offers words and auto requests; the slave side sends the bits.
interface serial_pattern_sender_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] data;
  logic             in_ready;
  logic             auto_start;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, data, auto_start,
    input  in_ready, out, out_valid, busy, done
  );

  modport slave (
    input  in_valid, data, auto_start,
    output in_ready, out, out_valid, busy, done
  );
endinterface

// File: rtl/serial_pattern_sender.sv
// MSB-first serialiser for single words, or for an auto sequence that counts 1..2^WIDTH-1.
// An optional idle gap follows each word; done pulses once per manual word or once per sequence.
module serial_pattern_sender #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned GAP   = 0
) (
  input logic                   clk,
  input logic                   rst_n,
  serial_pattern_sender_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, PAUSE} state_t;

  localparam logic [3:0]       BIT_LAST = 4'(WIDTH - 1);
  localparam logic [3:0]       GAP_LAST = 4'(GAP - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_t           state, state_nxt;
  logic             auto_flag;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] counter;
  logic [3:0]       bit_cnt;
  logic [3:0]       gap_cnt;
  logic             done_r;

  logic start_auto, start_manual, last_bit, gap_last, word_end, seq_more;

  always_comb begin
    start_auto   = (state == IDLE) && bus.auto_start;
    start_manual = (state == IDLE) && bus.in_valid && !bus.auto_start;
    last_bit     = (state == SHIFT) && (bit_cnt == BIT_LAST);
    gap_last     = (state == PAUSE) && (gap_cnt == GAP_LAST);
    word_end     = (GAP == 0) ? last_bit : gap_last;
    seq_more     = auto_flag && (counter != ALL_ONES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_auto || start_manual) state_nxt = SHIFT;
      SHIFT: if (last_bit) state_nxt = (GAP != 0) ? PAUSE : (seq_more ? SHIFT : IDLE);
      PAUSE: if (gap_last) state_nxt = seq_more ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Word-end handling is placed last so it overrides the plain shift on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_flag <= 1'b0;
      shreg     <= '0;
      counter   <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      done_r    <= 1'b0;
    end else begin
      done_r <= word_end && !seq_more;

      if (start_auto) begin
        counter   <= ONE;
        shreg     <= ONE;
        auto_flag <= 1'b1;
        bit_cnt   <= '0;
      end else if (start_manual) begin
        shreg   <= bus.data;
        bit_cnt <= '0;
      end else if (state == SHIFT) begin
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt + 4'd1;
      end

      if (last_bit)
        gap_cnt <= '0;
      else if (state == PAUSE)
        gap_cnt <= gap_cnt + 4'd1;

      if (word_end) begin
        if (seq_more) begin
          counter <= counter + ONE;
          shreg   <= counter + ONE;
          bit_cnt <= '0;
        end else begin
          auto_flag <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == SHIFT);
    bus.out       = (state == SHIFT) && shreg[WIDTH-1];
    bus.busy      = (state != IDLE);
    bus.done      = done_r;
  end

endmodule

// File: tb/tb_serial_pattern_sender.sv
// Directed bench for serial_pattern_sender: WIDTH=4 with GAP=0 (dut_a) and GAP=2 (dut_b).
module tb_serial_pattern_sender;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  serial_pattern_sender_if #(.WIDTH(4)) ia ();
  serial_pattern_sender_if #(.WIDTH(4)) ib ();

  serial_pattern_sender #(.WIDTH(4), .GAP(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  serial_pattern_sender #(.WIDTH(4), .GAP(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] w;

  initial begin
    rst_n = 1'b0;
    ia.in_valid = 1'b0; ia.auto_start = 1'b0; ia.data = '0;
    ib.in_valid = 1'b0; ib.auto_start = 1'b0; ib.data = '0;

    #3;
    chk("rst_out",       32'(ia.out), 0);
    chk("rst_out_valid", 32'(ia.out_valid), 0);
    chk("rst_busy",      32'(ia.busy), 0);
    chk("rst_done",      32'(ia.done), 0);
    chk("rst_in_ready",  32'(ia.in_ready), 1);
    chk("rst_b_in_ready", 32'(ib.in_ready), 1);
    #19 rst_n = 1'b1;
    tick();

    // Manual 1101, GAP=0
    ia.in_valid = 1'b1; ia.data = 4'b1101; w = 4'b1101;
    tick();
    ia.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("m1_out",       32'(ia.out), 32'(w[3-i]));
      chk("m1_out_valid", 32'(ia.out_valid), 1);
      chk("m1_in_ready",  32'(ia.in_ready), 0);
      chk("m1_done_low",  32'(ia.done), 0);
      tick();
    end
    chk("m1_done",      32'(ia.done), 1);
    chk("m1_in_ready5", 32'(ia.in_ready), 1);
    chk("m1_valid5",    32'(ia.out_valid), 0);
    tick();
    chk("m1_done_once", 32'(ia.done), 0);

    // Manual 0110, GAP=2
    ib.in_valid = 1'b1; ib.data = 4'b0110; w = 4'b0110;
    tick();
    ib.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("g_out",       32'(ib.out), 32'(w[3-i]));
      chk("g_out_valid", 32'(ib.out_valid), 1);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      chk("g_gap_valid", 32'(ib.out_valid), 0);
      chk("g_gap_out",   32'(ib.out), 0);
      chk("g_gap_busy",  32'(ib.busy), 1);
      chk("g_gap_done",  32'(ib.done), 0);
      tick();
    end
    chk("g_done",     32'(ib.done), 1);
    chk("g_busy_end", 32'(ib.busy), 0);
    chk("g_in_ready", 32'(ib.in_ready), 1);
    tick();

    // in_valid pulsed mid-word is ignored
    ia.in_valid = 1'b1; ia.data = 4'b1010; w = 4'b1010;
    tick();
    ia.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin ia.in_valid = 1'b1; ia.data = 4'b0101; end
      if (i == 2) ia.in_valid = 1'b0;
      chk("ign_out", 32'(ia.out), 32'(w[3-i]));
      tick();
    end
    chk("ign_done", 32'(ia.done), 1);
    tick();
    chk("ign_no_queue", 32'(ia.out_valid), 0);
    ia.in_valid = 1'b1; ia.data = 4'b0011; w = 4'b0011;
    tick();
    ia.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("later_out", 32'(ia.out), 32'(w[3-i]));
      tick();
    end
    chk("later_done", 32'(ia.done), 1);
    tick();

    // Auto wins over in_valid; 15 words 0001..1111, one done at the end
    ia.in_valid = 1'b1; ia.auto_start = 1'b1; ia.data = 4'b1001;
    tick();
    ia.in_valid = 1'b0; ia.auto_start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      w = 4'(i / 4 + 1);
      chk("auto_out",       32'(ia.out), 32'(w[3 - (i % 4)]));
      chk("auto_out_valid", 32'(ia.out_valid), 1);
      chk("auto_busy",      32'(ia.busy), 1);
      chk("auto_done_low",  32'(ia.done), 0);
      tick();
    end
    chk("auto_done",     32'(ia.done), 1);
    chk("auto_busy_end", 32'(ia.busy), 0);
    chk("auto_no_zero",  32'(ia.out_valid), 0);
    tick();
    chk("auto_done_once", 32'(ia.done), 0);

    // Async reset during the 7th auto word, then manual 1000
    ia.auto_start = 1'b1;
    tick();
    ia.auto_start = 1'b0;
    repeat (25) tick();
    chk("w7_out",   32'(ia.out), 1);
    chk("w7_valid", 32'(ia.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out",      32'(ia.out), 0);
    chk("arst_valid",    32'(ia.out_valid), 0);
    chk("arst_busy",     32'(ia.busy), 0);
    chk("arst_done",     32'(ia.done), 0);
    chk("arst_in_ready", 32'(ia.in_ready), 1);
    tick();
    chk("arst_hold_done", 32'(ia.done), 0);
    chk("arst_hold_busy", 32'(ia.busy), 0);
    #6;
    rst_n = 1'b1;
    ia.in_valid = 1'b1; ia.data = 4'b1000; w = 4'b1000;
    tick();
    ia.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("post_out",   32'(ia.out), 32'(w[3-i]));
      chk("post_valid", 32'(ia.out_valid), 1);
      tick();
    end
    chk("post_done", 32'(ia.done), 1);
    chk("post_idle", 32'(ia.in_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_pattern_sender.md
SERIAL_PATTERN_SENDER -- requirements
Module: serial_pattern_sender

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the word length in bits (2..8).
REQ-002 The block SHALL have parameter GAP, default 0, giving the number of idle cycles inserted after each word (0..15).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1, meaning a word is offered on data.
REQ-006 The block SHALL have port data, input, WIDTH, the word to transmit; bit WIDTH-1 is sent first.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the block accepts a word this cycle.
REQ-008 The block SHALL have port auto_start, input, 1, a request to run the self-counting sequence.
REQ-009 The block SHALL have port out, output, 1, the serial bit stream feeding the detector input.
REQ-010 The block SHALL have port out_valid, output, 1, high while out carries a payload bit.
REQ-011 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-012 The block SHALL have port done, output, 1, a one-cycle pulse at the end of a word (manual) or of the whole sequence (auto).

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and PAUSE, plus a 1-bit auto flag.
REQ-014 In IDLE, in_ready SHALL be 1; in SHIFT and PAUSE, in_ready SHALL be 0.
REQ-015 Manual accept SHALL occur at a rising edge with state IDLE and in_valid=1 and auto_start=0: data is latched into a WIDTH-bit shift register, the bit counter is cleared, and the state goes to SHIFT.
REQ-016 In SHIFT, out SHALL equal the current MSB of the shift register, out_valid SHALL be 1, and the register SHALL shift left by one each cycle, so a word occupies exactly WIDTH consecutive cycles.
REQ-017 Accept-to-first-bit latency SHALL be one cycle: the first bit is on out in the cycle after the accepting edge.
REQ-018 After the WIDTH-th bit, the state SHALL go to PAUSE for GAP cycles when GAP>0, then go to IDLE; when GAP=0 it SHALL go directly to IDLE.
REQ-019 In IDLE and PAUSE, out SHALL be 0 and out_valid SHALL be 0.
REQ-020 In manual mode, done SHALL be 1 for exactly the one cycle in which the state first returns to IDLE after a word.
REQ-021 When in_valid and auto_start are both 1 in IDLE, auto_start SHALL win and data SHALL be ignored.
REQ-022 On auto_start=1 in IDLE, an internal WIDTH-bit counter SHALL load 1, the auto flag SHALL be set, the counter value SHALL be sent as a word, and the state goes to SHIFT.
REQ-023 In auto mode, after each word and its GAP cycles, the counter SHALL increment, and the next word SHALL start without passing through IDLE.
REQ-024 The auto sequence SHALL end after the word of all ones (2^WIDTH-1); the counter SHALL never wrap to 0 and zero SHALL never be sent.
REQ-025 At the end of the auto sequence, the auto flag SHALL clear, the state SHALL go to IDLE, and done SHALL pulse once only then, not after each word.
REQ-026 In SHIFT or PAUSE, in_valid and auto_start SHALL be ignored, with no queuing.

Reset
REQ-027 While rst_n=0, regardless of clk, the block SHALL force state IDLE, auto flag 0, shift register 0, counters 0, out 0, out_valid 0, busy 0, done 0 and in_ready 1.
REQ-028 Reset asserted mid-word or mid-sequence SHALL abort immediately with no done pulse; after release, the block SHALL accept a new request on the first rising edge.

Verification (WIDTH=4, GAP=0 unless stated)
REQ-029 Manual send of data=4'b1101 -> out = 1,1,0,1 on cycles 1-4 after accept, out_valid high for exactly 4 cycles, done high in cycle 5, in_ready back to 1 in cycle 5.
REQ-030 GAP=2, manual send of 4'b0110 -> bits 0,1,1,0, then 2 cycles with out_valid=0 and busy=1, then IDLE with done=1.
REQ-031 Auto sequence -> 15 words 0001 through 1111 MSB-first, 60 contiguous valid cycles, busy high throughout, exactly one done pulse after 1111, no 0000 word.
REQ-032 in_valid and auto_start asserted together in IDLE -> auto sequence runs; data is not sent.
REQ-033 in_valid pulsed during SHIFT -> ignored; the current word completes unchanged, and only a later in_valid in IDLE is sent.
REQ-034 rst_n dropped asynchronously during the 7th auto word -> out, out_valid and busy go to 0 at once, with no done pulse; after release, a manual send of 4'b1000 transmits correctly.
